// File: rtl/f3m_mult3_pkg.sv
// Shared GF(3^97) constants, lane state encoding and trit/element helpers
// used by the three-lane serial multiplier.
package f3m_mult3_pkg;

    localparam int M     = 97;
    localparam int WIDTH = 2 * M - 1;
    localparam int TAP   = 12;

    localparam logic [1:0] TRIT_0 = 2'b00;
    localparam logic [1:0] TRIT_1 = 2'b01;
    localparam logic [1:0] TRIT_2 = 2'b10;

    localparam logic [6:0] CNT_INIT = 7'(M - 1);

    typedef enum logic [1:0] {
        ST_START = 2'b00,
        ST_RUN   = 2'b01,
        ST_DONE  = 2'b10
    } lane_state_t;

    function automatic logic [1:0] f3_add(input logic [1:0] x, input logic [1:0] y);
        logic [1:0] s;
        case ({x, y})
            4'b0000: s = TRIT_0;
            4'b0001: s = TRIT_1;
            4'b0010: s = TRIT_2;
            4'b0100: s = TRIT_1;
            4'b0101: s = TRIT_2;
            4'b0110: s = TRIT_0;
            4'b1000: s = TRIT_2;
            4'b1001: s = TRIT_0;
            4'b1010: s = TRIT_1;
            default: s = TRIT_0;
        endcase
        return s;
    endfunction

    function automatic logic [1:0] f3_neg(input logic [1:0] x);
        return {x[0], x[1]};
    endfunction

    // v*x mod p, using x^97 = 2x^12 + 1
    function automatic logic [WIDTH:0] f3m_mul_x(input logic [WIDTH:0] v);
        logic [1:0]     t;
        logic [WIDTH:0] r;
        t = v[WIDTH -: 2];
        r = {v[WIDTH-2:0], t};
        r[2*TAP+1 -: 2] = f3_add(v[2*TAP-1 -: 2], f3_neg(t));
        return r;
    endfunction

    function automatic logic [WIDTH:0] f3m_scale(input logic [WIDTH:0] v, input logic [1:0] k);
        logic [WIDTH:0] r;
        r = '0;
        for (int i = 0; i < M; i++) begin
            case (k)
                TRIT_1:  r[2*i +: 2] = v[2*i +: 2];
                TRIT_2:  r[2*i +: 2] = f3_neg(v[2*i +: 2]);
                default: r[2*i +: 2] = TRIT_0;
            endcase
        end
        return r;
    endfunction

    function automatic logic [WIDTH:0] f3m_add(input logic [WIDTH:0] x, input logic [WIDTH:0] y);
        logic [WIDTH:0] r;
        r = '0;
        for (int i = 0; i < M; i++) begin
            r[2*i +: 2] = f3_add(x[2*i +: 2], y[2*i +: 2]);
        end
        return r;
    endfunction

endpackage

// File: rtl/f3m_mult_serial.sv
// One bit-serial GF(3^97) multiplier lane: Horner evaluation over the
// coefficients of b, most significant first, one coefficient per clock.
//
// state    | meaning
// ST_START | first edge after reset release, consumes b[96]
// ST_RUN   | consumes b[cnt], cnt counting 95 down to 0
// ST_DONE  | result valid, everything frozen until next reset
module f3m_mult_serial
    import f3m_mult3_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic [WIDTH:0] a,
    input  logic [WIDTH:0] b,
    output logic [WIDTH:0] c,
    output logic           done
);

    lane_state_t    state;
    logic [6:0]     cnt;
    logic [6:0]     idx;
    logic [1:0]     b_trit;
    logic [WIDTH:0] c_next;

    // The counter clears to 0 on reset, so the very first step takes its
    // index from the state rather than from the counter.
    always_comb begin
        idx    = (state == ST_START) ? CNT_INIT : cnt;
        b_trit = TRIT_0;
        for (int k = 0; k < M; k++) begin
            if (idx == 7'(k)) begin
                b_trit = b[2*k +: 2];
            end
        end
        c_next = f3m_add(f3m_mul_x(c), f3m_scale(a, b_trit));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_START;
            cnt   <= '0;
            c     <= '0;
            done  <= 1'b0;
        end else begin
            case (state)
                ST_START: begin
                    c     <= c_next;
                    cnt   <= CNT_INIT - 7'd1;
                    state <= ST_RUN;
                end
                ST_RUN: begin
                    c <= c_next;
                    if (cnt == 7'd0) begin
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        cnt <= cnt - 7'd1;
                    end
                end
                ST_DONE: begin
                    done <= 1'b1;
                end
                default: begin
                    state <= ST_START;
                end
            endcase
        end
    end

endmodule

// File: rtl/f3m_mult3.sv
// Three concurrent GF(3^97) serial multipliers sharing one start (reset
// release) and one combined done flag.
module f3m_mult3
    import f3m_mult3_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic [WIDTH:0] a0,
    input  logic [WIDTH:0] b0,
    input  logic [WIDTH:0] a1,
    input  logic [WIDTH:0] b1,
    input  logic [WIDTH:0] a2,
    input  logic [WIDTH:0] b2,
    output logic [WIDTH:0] c0,
    output logic [WIDTH:0] c1,
    output logic [WIDTH:0] c2,
    output logic           done
);

    logic done_0;
    logic done_1;
    logic done_2;

    f3m_mult_serial u_lane0 (
        .clk   (clk),
        .reset (reset),
        .a     (a0),
        .b     (b0),
        .c     (c0),
        .done  (done_0)
    );

    f3m_mult_serial u_lane1 (
        .clk   (clk),
        .reset (reset),
        .a     (a1),
        .b     (b1),
        .c     (c1),
        .done  (done_1)
    );

    f3m_mult_serial u_lane2 (
        .clk   (clk),
        .reset (reset),
        .a     (a2),
        .b     (b2),
        .c     (c2),
        .done  (done_2)
    );

    // Lanes are lock-stepped; the AND only guards against a lane diverging.
    assign done = done_0 & done_1 & done_2;

endmodule

// File: tb/tb_f3m_mult3.sv
// Self-checking bench for f3m_mult3: constant vectors plus a schoolbook
// GF(3^97) reference model, results queued at stimulus and popped at done.
module tb_f3m_mult3;

    localparam int N = 194;

    logic         clk;
    logic         reset;
    logic [N-1:0] a0, b0, a1, b1, a2, b2;
    logic [N-1:0] c0, c1, c2;
    logic         done;

    typedef struct {
        logic [N-1:0] e0;
        logic [N-1:0] e1;
        logic [N-1:0] e2;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    localparam logic [N-1:0] GA = 194'h2581921511a6952a4244918a069446a520480660152916412;
    localparam logic [N-1:0] GB = 194'h158a5419212805158a941010a495a80966995599a660686a5;
    localparam logic [N-1:0] GC = 194'h145a548a114016289482246816a449911942a088540160102;

    f3m_mult3 dut (
        .clk   (clk),
        .reset (reset),
        .a0    (a0),
        .b0    (b0),
        .a1    (a1),
        .b1    (b1),
        .a2    (a2),
        .b2    (b2),
        .c0    (c0),
        .c1    (c1),
        .c2    (c2),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [N-1:0] rand_elem();
        logic [N-1:0] v;
        v = '0;
        for (int i = 0; i < 97; i++) v[2*i +: 2] = 2'($urandom_range(0, 2));
        return v;
    endfunction

    function automatic int trit_val(input logic [1:0] t);
        return (t == 2'b01) ? 1 : ((t == 2'b10) ? 2 : 0);
    endfunction

    // Full polynomial product, then reduction of degrees 192..97 downward.
    function automatic logic [N-1:0] gf_mul(input logic [N-1:0] x, input logic [N-1:0] y);
        int           prod[193];
        int           t;
        logic [N-1:0] r;
        for (int k = 0; k < 193; k++) prod[k] = 0;
        for (int i = 0; i < 97; i++)
            for (int j = 0; j < 97; j++)
                prod[i+j] = (prod[i+j] + trit_val(x[2*i +: 2]) * trit_val(y[2*j +: 2])) % 3;
        for (int k = 192; k >= 97; k--) begin
            t = prod[k];
            prod[k] = 0;
            prod[k-97] = (prod[k-97] + t) % 3;
            prod[k-85] = (prod[k-85] + 2 * t) % 3;
        end
        r = '0;
        for (int k = 0; k < 97; k++) r[2*k +: 2] = (prod[k] == 1) ? 2'b01 : ((prod[k] == 2) ? 2'b10 : 2'b00);
        return r;
    endfunction

    function automatic bit has_11(input logic [N-1:0] v);
        bit f;
        f = 1'b0;
        for (int i = 0; i < 97; i++) if (v[2*i +: 2] == 2'b11) f = 1'b1;
        return f;
    endfunction

    // Drives operands, queues the expected products, pulses reset and waits
    // for done; lat is the edge count after release, -1 on timeout.
    task automatic start_op(input logic [N-1:0] xa0, input logic [N-1:0] xb0,
                            input logic [N-1:0] xa1, input logic [N-1:0] xb1,
                            input logic [N-1:0] xa2, input logic [N-1:0] xb2,
                            input exp_t e, output int lat);
        @(negedge clk);
        reset = 1'b1;
        a0 = xa0; b0 = xb0; a1 = xa1; b1 = xb1; a2 = xa2; b2 = xb2;
        exp_q.push_back(e);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        lat = -1;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        a0 = rand_elem(); b0 = rand_elem(); a1 = rand_elem();
        b1 = rand_elem(); a2 = rand_elem(); b2 = rand_elem();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", done); end
        checks++; if (c0 !== '0) begin errors++; $display("FAIL reset_c0 got=%h want=0", c0); end
        checks++; if (c1 !== '0) begin errors++; $display("FAIL reset_c1 got=%h want=0", c1); end
        checks++; if (c2 !== '0) begin errors++; $display("FAIL reset_c2 got=%h want=0", c2); end
    endtask

    task automatic test_identity();
        logic [N-1:0] one, x0, x1, x2;
        exp_t e, s;
        int lat;
        one = 194'h1;
        x0 = rand_elem(); x1 = rand_elem(); x2 = rand_elem();
        e.e0 = x0; e.e1 = x1; e.e2 = x2;
        start_op(one, x0, one, x1, one, x2, e, lat);
        s = exp_q.pop_front();
        checks++; if (lat != 97) begin errors++; $display("FAIL identity_latency got=%0d want=97", lat); end
        checks++; if (c0 !== s.e0) begin errors++; $display("FAIL identity_c0 got=%h want=%h", c0, s.e0); end
        checks++; if (c1 !== s.e1) begin errors++; $display("FAIL identity_c1 got=%h want=%h", c1, s.e1); end
        checks++; if (c2 !== s.e2) begin errors++; $display("FAIL identity_c2 got=%h want=%h", c2, s.e2); end
    endtask

    task automatic test_zero();
        logic [N-1:0] xa1, xb1, xb0, xa2;
        exp_t e, s;
        int lat;
        xb0 = rand_elem(); xa1 = rand_elem(); xb1 = rand_elem(); xa2 = rand_elem();
        e.e0 = '0; e.e1 = gf_mul(xa1, xb1); e.e2 = '0;
        start_op('0, xb0, xa1, xb1, xa2, '0, e, lat);
        s = exp_q.pop_front();
        checks++; if (lat != 97) begin errors++; $display("FAIL zero_latency got=%0d want=97", lat); end
        checks++; if (c0 !== s.e0) begin errors++; $display("FAIL zero_c0 got=%h want=%h", c0, s.e0); end
        checks++; if (c1 !== s.e1) begin errors++; $display("FAIL zero_c1 got=%h want=%h", c1, s.e1); end
        checks++; if (c2 !== s.e2) begin errors++; $display("FAIL zero_c2 got=%h want=%h", c2, s.e2); end
    endtask

    task automatic test_reduction();
        logic [N-1:0] xa, xb;
        exp_t e, s;
        int lat;
        xa = '0; xa[192] = 1'b1;
        xb = 194'h4;
        e.e0 = 194'h2000001; e.e1 = 194'h2000001; e.e2 = 194'h2000001;
        start_op(xa, xb, xa, xb, xa, xb, e, lat);
        s = exp_q.pop_front();
        checks++; if (lat != 97) begin errors++; $display("FAIL reduce_latency got=%0d want=97", lat); end
        checks++; if (c0 !== s.e0) begin errors++; $display("FAIL reduce_c0 got=%h want=%h", c0, s.e0); end
        checks++; if (c1 !== s.e1) begin errors++; $display("FAIL reduce_c1 got=%h want=%h", c1, s.e1); end
        checks++; if (c2 !== s.e2) begin errors++; $display("FAIL reduce_c2 got=%h want=%h", c2, s.e2); end
    endtask

    task automatic test_golden();
        logic [N-1:0] xa1, xb1, xa2, xb2;
        exp_t e, s;
        int lat;
        xa1 = rand_elem(); xb1 = rand_elem(); xa2 = rand_elem(); xb2 = rand_elem();
        e.e0 = GC; e.e1 = gf_mul(xa1, xb1); e.e2 = gf_mul(xa2, xb2);
        start_op(GA, GB, xa1, xb1, xa2, xb2, e, lat);
        s = exp_q.pop_front();
        checks++; if (lat != 97) begin errors++; $display("FAIL golden_latency got=%0d want=97", lat); end
        checks++; if (c0 !== s.e0) begin errors++; $display("FAIL golden_c0 got=%h want=%h", c0, s.e0); end
        checks++; if (c1 !== s.e1) begin errors++; $display("FAIL golden_c1 got=%h want=%h", c1, s.e1); end
        checks++; if (c2 !== s.e2) begin errors++; $display("FAIL golden_c2 got=%h want=%h", c2, s.e2); end
        checks++; if (has_11(c0) || has_11(c1) || has_11(c2)) begin
            errors++; $display("FAIL golden_code11 got=present want=absent");
        end
        // Same vectors rotated across lanes.
        e.e0 = gf_mul(xa2, xb2); e.e1 = GC; e.e2 = gf_mul(xa1, xb1);
        start_op(xa2, xb2, GA, GB, xa1, xb1, e, lat);
        s = exp_q.pop_front();
        checks++; if (lat != 97) begin errors++; $display("FAIL swap_latency got=%0d want=97", lat); end
        checks++; if (c0 !== s.e0) begin errors++; $display("FAIL swap_c0 got=%h want=%h", c0, s.e0); end
        checks++; if (c1 !== s.e1) begin errors++; $display("FAIL swap_c1 got=%h want=%h", c1, s.e1); end
        checks++; if (c2 !== s.e2) begin errors++; $display("FAIL swap_c2 got=%h want=%h", c2, s.e2); end
        // Results must hold after done.
        repeat (10) @(posedge clk);
        #1;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL hold_done got=%b want=1", done); end
        checks++; if (c1 !== s.e1) begin errors++; $display("FAIL hold_c1 got=%h want=%h", c1, s.e1); end
    endtask

    task automatic test_mid_reset();
        logic [N-1:0] xa0, xb0, xa1, xb1, xa2, xb2;
        exp_t e, s;
        int lat;
        xa0 = rand_elem(); xb0 = rand_elem(); xa1 = rand_elem();
        xb1 = rand_elem(); xa2 = rand_elem(); xb2 = rand_elem();
        @(negedge clk);
        reset = 1'b1;
        a0 = xa0; b0 = xb0; a1 = xa1; b1 = xb1; a2 = xa2; b2 = xb2;
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrun_done got=%b want=0", done); end
        reset = 1'b1;
        #1;
        checks++; if (c0 !== '0 || done !== 1'b0) begin
            errors++; $display("FAIL abort_clear got=%h/%b want=0/0", c0, done);
        end
        e.e0 = gf_mul(xa0, xb0); e.e1 = gf_mul(xa1, xb1); e.e2 = gf_mul(xa2, xb2);
        start_op(xa0, xb0, xa1, xb1, xa2, xb2, e, lat);
        s = exp_q.pop_front();
        checks++; if (lat != 97) begin errors++; $display("FAIL restart_latency got=%0d want=97", lat); end
        checks++; if (c0 !== s.e0) begin errors++; $display("FAIL restart_c0 got=%h want=%h", c0, s.e0); end
        checks++; if (c1 !== s.e1) begin errors++; $display("FAIL restart_c1 got=%h want=%h", c1, s.e1); end
        checks++; if (c2 !== s.e2) begin errors++; $display("FAIL restart_c2 got=%h want=%h", c2, s.e2); end
    endtask

    task automatic test_random();
        logic [N-1:0] xa0, xb0, xa1, xb1, xa2, xb2;
        exp_t e, s;
        int lat;
        for (int r = 0; r < 3; r++) begin
            xa0 = rand_elem(); xb0 = rand_elem(); xa1 = rand_elem();
            xb1 = rand_elem(); xa2 = rand_elem(); xb2 = rand_elem();
            e.e0 = gf_mul(xa0, xb0); e.e1 = gf_mul(xa1, xb1); e.e2 = gf_mul(xa2, xb2);
            start_op(xa0, xb0, xa1, xb1, xa2, xb2, e, lat);
            s = exp_q.pop_front();
            checks++; if (lat != 97) begin errors++; $display("FAIL rand%0d_latency got=%0d want=97", r, lat); end
            checks++; if (c0 !== s.e0) begin errors++; $display("FAIL rand%0d_c0 got=%h want=%h", r, c0, s.e0); end
            checks++; if (c1 !== s.e1) begin errors++; $display("FAIL rand%0d_c1 got=%h want=%h", r, c1, s.e1); end
            checks++; if (c2 !== s.e2) begin errors++; $display("FAIL rand%0d_c2 got=%h want=%h", r, c2, s.e2); end
        end
    endtask

    initial begin
        reset = 1'b1;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0; a2 = '0; b2 = '0;
        test_reset();
        test_identity();
        test_zero();
        test_reduction();
        test_golden();
        test_mid_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
